audio_frame_arbiter: RTL and testbench
======================================

AUDIO_FRAME_ARBITER -- requirements
Module: audio_frame_arbiter

Interface
REQ-001 SHALL have parameter SAMPLES, default 59: 16-bit samples per UDP frame, legal range 1..127.
REQ-002 SHALL have parameter SYNC, default 8'hA5: header sync byte.
REQ-003 SHALL have port clk, input, 1: single clock for all logic.
REQ-004 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port enable, input, 1: sample capture enable.
REQ-006 SHALL have port wav_in_data_0, input, 16: channel 0 sample.
REQ-007 SHALL have port wav_wren_0, input, 1: channel 0 sample strobe, one cycle per sample.
REQ-008 SHALL have port wav_in_data_1, input, 16: channel 1 sample.
REQ-009 SHALL have port wav_wren_1, input, 1: channel 1 sample strobe.
REQ-010 SHALL have port udp_send_data_valid, output, 1: frame offered.
REQ-011 SHALL have port udp_send_data_ready, input, 1: sink accepts.
REQ-012 SHALL have port udp_send_data, output, 16*(SAMPLES+1): frame payload.
REQ-013 SHALL have port udp_send_data_length, output, 16: payload bytes, constant 2*(SAMPLES+1), 120 at default.
REQ-014 SHALL have ports drop_cnt_0 and drop_cnt_1, output, 8 each: per-channel dropped-frame count.

Function
REQ-015 Each channel SHALL own a fill buffer, a 7-bit write index, a hold buffer with a pending flag, and a 7-bit sequence counter.
REQ-016 While enable=1, each wav_wren_x SHALL write wav_in_data_x into fill slot index and then increment index.
- Both channels are independent.
- Both strobes in the same cycle are both accepted.
REQ-017 Frame completion is a strobe at index SAMPLES-1; the index SHALL return to 0 on that strobe.
- The next strobe writes slot 0 with no gap.
REQ-018 On completion with pending=0, or with pending being cleared by a handshake in the same cycle:
- the completed frame plus the current seq SHALL be copied to hold on the next edge;
- pending SHALL be set.
REQ-019 On completion with pending=1 and no same-cycle handshake:
- the frame SHALL be dropped;
- drop_cnt_x SHALL increment, saturating at 255.
REQ-020 Seq SHALL increment, wrapping 127->0, on every completion, kept or dropped, so that gaps expose drops.
REQ-021 With enable=0:
- strobes SHALL be ignored;
- write indices SHALL clear to 0, discarding partial frames;
- pending frames SHALL still be sent.
REQ-022 Frame format:
- top word SHALL be the header {ch[15], seq[14:8], SYNC[7:0]};
- word k+1 below it SHALL be sample k, with sample 0 directly under the header.
REQ-023 The arbiter FSM SHALL have two states, IDLE and SEND.
REQ-024 IDLE -> SEND SHALL occur when any pending=1.
- Entering SEND latches the grant and loads udp_send_data from the granted hold buffer.
- udp_send_data_valid=1 from the next cycle.
REQ-025 Grant SHALL be round-robin: with both pending, the channel not last granted wins.
- last-granted resets to 1, so channel 0 wins first.
REQ-026 In SEND:
- valid SHALL stay 1;
- udp_send_data SHALL stay stable until ready=1 is sampled high.
REQ-027 On valid=1 and ready=1:
- the granted pending flag SHALL clear;
- last-granted SHALL update;
- FSM SHALL return to IDLE with valid=0 next cycle, giving one bubble cycle minimum between frames.
REQ-028 Ready SHALL be ignored while valid=0.
REQ-029 Latency: a completion strobe at cycle t with the arbiter idle SHALL give valid=1 at cycle t+2.

Reset
REQ-030 rst_n=0 SHALL asynchronously clear all of the following:
- FSM to IDLE;
- valid to 0 and udp_send_data to 0;
- indices, pending flags, seq counters and drop counters to 0;
- last-granted to 1.
REQ-031 udp_send_data_length SHALL read 2*(SAMPLES+1) during and after reset.
REQ-032 Reset mid-SEND SHALL abort the frame with no handshake and no drop count.
REQ-033 Deassertion SHALL be synchronized to clk.

Verification
REQ-034 With SAMPLES=4, enable=1, ready=1, send ch0 samples 1,2,3,4 -> one frame 80'h00A5_0001_0002_0003_0004, length 10, valid high exactly 1 cycle, at t+2 after the 4th strobe.
REQ-035 Ch0 and ch1 complete in the same cycle, ready=1 -> ch0 frame sent first, then ch1 with header 16'h80A5, with one IDLE cycle between them.
REQ-036 ready=0 held while ch0 completes 3 frames -> drop_cnt_0=1; the delivered frames carry seq 0 and 1; the next frame after release carries seq 3; payload stays stable while stalled.
REQ-037 enable=0 after 2 of 4 strobes, then re-enable and send 4 samples -> exactly one frame, containing only the last 4 samples.
REQ-038 Assert rst_n=0 during SEND -> valid=0 immediately; after release, the first frame of ch0 carries seq 0 and drop_cnt_0=0.
REQ-039 Complete 130 ch1 frames with ready=1 -> seq wraps 127->0 and drop_cnt_1 stays 0.

Source files
------------

// File: rtl/audio_frame_arbiter.sv
// Two-channel audio framer: each channel packs SAMPLES 16-bit words behind a
// header into a hold buffer, and a round-robin arbiter offers frames to the UDP sink.

module audio_frame_chan #(
    parameter int         SAMPLES = 59,
    parameter logic [7:0] SYNC    = 8'hA5,
    parameter int         CH      = 0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        enable_i,
    input  logic [15:0]                 data_i,
    input  logic                        wren_i,
    input  logic                        clr_i,
    output logic [16*(SAMPLES+1)-1:0]   hold_o,
    output logic                        pend_o,
    output logic [7:0]                  drop_o
);
    localparam int         FW   = 16*(SAMPLES+1);
    localparam logic [6:0] LAST = 7'(SAMPLES-1);

    logic [SAMPLES-1:0][15:0] fill_q;
    logic [6:0]               idx_q, idx_d;
    logic [6:0]               seq_q, seq_d;
    logic [FW-1:0]            hold_q, hold_d;
    logic [FW-1:0]            frame;
    logic                     pend_q, pend_d;
    logic [7:0]               drop_q, drop_d;
    logic                     wr, done;

    assign wr   = enable_i & wren_i;
    assign done = wr & (idx_q == LAST);

    // The completing sample is still on data_i, so splice it in directly.
    always_comb begin
        frame = '0;
        frame[FW-1 -: 16] = {1'(CH), seq_q, SYNC};
        for (int k = 0; k < SAMPLES; k++) begin
            frame[16*(SAMPLES-1-k) +: 16] = (k == SAMPLES-1) ? data_i : fill_q[k];
        end
    end

    always_comb begin
        idx_d  = idx_q;
        seq_d  = seq_q + {6'd0, done};
        hold_d = hold_q;
        pend_d = pend_q & ~clr_i;
        drop_d = drop_q;
        if (!enable_i) begin
            idx_d = '0;
        end else if (wr) begin
            idx_d = done ? 7'd0 : idx_q + 7'd1;
        end
        if (done) begin
            if (!pend_q || clr_i) begin
                hold_d = frame;
                pend_d = 1'b1;
            end else if (drop_q != 8'hFF) begin
                drop_d = drop_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_q <= '0;
            idx_q  <= '0;
            seq_q  <= '0;
            hold_q <= '0;
            pend_q <= 1'b0;
            drop_q <= '0;
        end else begin
            for (int s = 0; s < SAMPLES; s++) begin
                if (wr && idx_q == 7'(s)) fill_q[s] <= data_i;
            end
            idx_q  <= idx_d;
            seq_q  <= seq_d;
            hold_q <= hold_d;
            pend_q <= pend_d;
            drop_q <= drop_d;
        end
    end

    assign hold_o = hold_q;
    assign pend_o = pend_q;
    assign drop_o = drop_q;
endmodule

module audio_frame_arbiter #(
    parameter int         SAMPLES = 59,
    parameter logic [7:0] SYNC    = 8'hA5
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        enable,
    input  logic [15:0]                 wav_in_data_0,
    input  logic                        wav_wren_0,
    input  logic [15:0]                 wav_in_data_1,
    input  logic                        wav_wren_1,
    output logic                        udp_send_data_valid,
    input  logic                        udp_send_data_ready,
    output logic [16*(SAMPLES+1)-1:0]   udp_send_data,
    output logic [15:0]                 udp_send_data_length,
    output logic [7:0]                  drop_cnt_0,
    output logic [7:0]                  drop_cnt_1
);
    localparam int         FW   = 16*(SAMPLES+1);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SEND = 1'b1;

    logic [1:0]          rst_sync_q;
    logic                rst_int_n;
    logic [1:0][15:0]    ch_data;
    logic [1:0]          ch_wren;
    logic [1:0][FW-1:0]  hold;
    logic [1:0]          pend, clr;
    logic [1:0][7:0]     drop;

    logic [0:0]          state_q, state_d;
    logic                gnt_q, gnt_d;
    logic                last_q, last_d;
    logic [FW-1:0]       data_q, data_d;

    // Assertion is immediate; release waits two clock edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync_q <= '0;
        else        rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_int_n = rst_sync_q[1];

    assign ch_data = {wav_in_data_1, wav_in_data_0};
    assign ch_wren = {wav_wren_1, wav_wren_0};

    for (genvar c = 0; c < 2; c++) begin : g_ch
        audio_frame_chan #(.SAMPLES(SAMPLES), .SYNC(SYNC), .CH(c)) u_ch (
            .clk     (clk),
            .rst_n   (rst_int_n),
            .enable_i(enable),
            .data_i  (ch_data[c]),
            .wren_i  (ch_wren[c]),
            .clr_i   (clr[c]),
            .hold_o  (hold[c]),
            .pend_o  (pend[c]),
            .drop_o  (drop[c])
        );
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        data_d  = data_q;
        clr     = '0;
        case (state_q)
            IDLE: begin
                if (|pend) begin
                    gnt_d   = (pend == 2'b11) ? ~last_q : pend[1];
                    data_d  = hold[gnt_d];
                    state_d = SEND;
                end
            end
            default: begin
                if (udp_send_data_ready) begin
                    clr[gnt_q] = 1'b1;
                    last_d     = gnt_q;
                    state_d    = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q <= IDLE;
            gnt_q   <= 1'b0;
            last_q  <= 1'b1;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            data_q  <= data_d;
        end
    end

    assign udp_send_data_valid  = (state_q == SEND);
    assign udp_send_data        = data_q;
    assign udp_send_data_length = 16'(2*(SAMPLES+1));
    assign drop_cnt_0           = drop[0];
    assign drop_cnt_1           = drop[1];
endmodule

// File: tb/tb_audio_frame_arbiter.sv
// Directed bench for audio_frame_arbiter at SAMPLES=4: a cycle table for the
// basic flow and round-robin, then hand sequences for stall, enable, reset, wrap.

module tb_audio_frame_arbiter;
    localparam int S  = 4;
    localparam int FW = 16*(S+1);

    logic          clk, rst_n, enable;
    logic [15:0]   d0, d1;
    logic          w0, w1, ready;
    logic          valid;
    logic [FW-1:0] data;
    logic [15:0]   len;
    logic [7:0]    drop0, drop1;

    audio_frame_arbiter #(.SAMPLES(S), .SYNC(8'hA5)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .enable              (enable),
        .wav_in_data_0       (d0),
        .wav_wren_0          (w0),
        .wav_in_data_1       (d1),
        .wav_wren_1          (w1),
        .udp_send_data_valid (valid),
        .udp_send_data_ready (ready),
        .udp_send_data       (data),
        .udp_send_data_length(len),
        .drop_cnt_0          (drop0),
        .drop_cnt_1          (drop1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          en;
        logic          w0;
        logic [15:0]   d0;
        logic          w1;
        logic [15:0]   d1;
        logic          ev;
        logic [FW-1:0] ed;
    } vec_t;

    vec_t tbl [15];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [FW-1:0] fr(input logic ch, input logic [6:0] seq, input logic [15:0] base);
        return {ch, seq, 8'hA5, base, base + 16'd1, base + 16'd2, base + 16'd3};
    endfunction

    // Called at a negedge: drive, cross one posedge, return at the next negedge.
    task automatic step(input logic en, input logic a, input logic [15:0] da,
                        input logic b, input logic [15:0] db);
        enable = en; w0 = a; d0 = da; w1 = b; d1 = db;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 16'h0, 1'b0, 16'h0);
    endtask

    task automatic send_frame(input int ch, input logic [15:0] base);
        for (int k = 0; k < S; k++)
            step(1'b1, ch == 0, base + 16'(k), ch == 1, base + 16'(k));
    endtask

    task automatic wait_valid(input int budget);
        int n = 0;
        while (!valid && n < budget) begin
            idle();
            n++;
        end
        checks++;
        if (!valid) begin
            errors++;
            $display("FAIL wait_valid timeout got valid=%0b expected 1", valid);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        enable = 1'b1; w0 = 1'b0; w1 = 1'b0; d0 = '0; d1 = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) idle();
    endtask

    initial begin
        int vcnt;
        tbl[0]  = '{1'b1, 1'b1, 16'h0001, 1'b0, 16'h0000, 1'b0, '0};
        tbl[1]  = '{1'b1, 1'b1, 16'h0002, 1'b0, 16'h0000, 1'b0, '0};
        tbl[2]  = '{1'b1, 1'b1, 16'h0003, 1'b0, 16'h0000, 1'b0, '0};
        tbl[3]  = '{1'b1, 1'b1, 16'h0004, 1'b0, 16'h0000, 1'b0, '0};
        tbl[4]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 80'h00A5_0001_0002_0003_0004};
        tbl[5]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, '0};
        tbl[6]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, '0};
        tbl[7]  = '{1'b1, 1'b1, 16'h0010, 1'b1, 16'h0020, 1'b0, '0};
        tbl[8]  = '{1'b1, 1'b1, 16'h0011, 1'b1, 16'h0021, 1'b0, '0};
        tbl[9]  = '{1'b1, 1'b1, 16'h0012, 1'b1, 16'h0022, 1'b0, '0};
        tbl[10] = '{1'b1, 1'b1, 16'h0013, 1'b1, 16'h0023, 1'b0, '0};
        tbl[11] = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 80'h80A5_0020_0021_0022_0023};
        tbl[12] = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, '0};
        tbl[13] = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 80'h01A5_0010_0011_0012_0013};
        tbl[14] = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, '0};

        rst_n = 1'b0; ready = 1'b1;
        enable = 1'b1; w0 = 1'b0; w1 = 1'b0; d0 = '0; d1 = '0;
        repeat (2) @(negedge clk);
        chk("reset_valid", valid, 0);
        chk("reset_data", data, 0);
        chk("reset_drop0", drop0, 0);
        chk("reset_drop1", drop1, 0);
        chk("reset_length", len, 80'd10);
        rst_n = 1'b1;
        repeat (3) idle();
        chk("length_after_reset", len, 80'd10);

        // Single ch0 frame, then simultaneous completions with ch0 last granted.
        for (int i = 0; i < 15; i++) begin
            step(tbl[i].en, tbl[i].w0, tbl[i].d0, tbl[i].w1, tbl[i].d1);
            chk($sformatf("tbl[%0d].valid", i), valid, tbl[i].ev);
            if (tbl[i].ev) chk($sformatf("tbl[%0d].data", i), data, tbl[i].ed);
        end

        // Fresh reset: simultaneous completion grants ch0 first.
        do_reset();
        for (int k = 0; k < S; k++)
            step(1'b1, 1'b1, 16'h0030 + 16'(k), 1'b1, 16'h0040 + 16'(k));
        chk("rr_t1_valid", valid, 0);
        idle(); chk("rr_first_valid", valid, 1); chk("rr_first_data", data, fr(1'b0, 7'd0, 16'h0030));
        idle(); chk("rr_bubble", valid, 0);
        idle(); chk("rr_second_valid", valid, 1); chk("rr_second_data", data, fr(1'b1, 7'd0, 16'h0040));
        idle(); chk("rr_done", valid, 0);

        // Stall: seq1 held on the bus, seq2 dropped, seq3 follows release.
        do_reset();
        send_frame(0, 16'h0100); wait_valid(6);
        chk("stall_seq0", data, fr(1'b0, 7'd0, 16'h0100));
        idle(); chk("stall_seq0_hs", valid, 0);
        ready = 1'b0;
        send_frame(0, 16'h0200); wait_valid(6);
        chk("stall_seq1", data, fr(1'b0, 7'd1, 16'h0200));
        for (int k = 0; k < S; k++) begin
            step(1'b1, 1'b1, 16'h0300 + 16'(k), 1'b0, 16'h0);
            chk("stall_stable_data", data, fr(1'b0, 7'd1, 16'h0200));
            chk("stall_stable_valid", valid, 1);
        end
        chk("stall_drop0", drop0, 1);
        ready = 1'b1;
        idle(); chk("stall_release", valid, 0);
        send_frame(0, 16'h0400); wait_valid(6);
        chk("stall_seq3", data, fr(1'b0, 7'd3, 16'h0400));
        idle();

        // Disable mid-frame discards the partial frame and ignores strobes.
        do_reset();
        step(1'b1, 1'b1, 16'h0011, 1'b0, 16'h0);
        step(1'b1, 1'b1, 16'h0012, 1'b0, 16'h0);
        step(1'b0, 1'b1, 16'h0099, 1'b0, 16'h0);
        send_frame(0, 16'h0005); wait_valid(6);
        chk("enable_frame", data, fr(1'b0, 7'd0, 16'h0005));
        idle();
        vcnt = 0;
        for (int k = 0; k < 8; k++) begin
            idle();
            if (valid) vcnt++;
        end
        chk("enable_single_frame", vcnt, 0);

        // Reset asserted mid-SEND.
        do_reset();
        ready = 1'b0;
        send_frame(0, 16'h0500); wait_valid(6);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_send_valid", valid, 0);
        chk("rst_send_data", data, 0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        repeat (3) idle();
        ready = 1'b1;
        send_frame(0, 16'h0600); wait_valid(6);
        chk("rst_first_frame", data, fr(1'b0, 7'd0, 16'h0600));
        chk("rst_drop0", drop0, 0);
        idle();

        // 130 ch1 frames: sequence wraps 127 -> 0 without drops.
        do_reset();
        for (int i = 0; i < 130; i++) begin
            send_frame(1, 16'(i * 4));
            wait_valid(6);
            chk($sformatf("wrap_frame_%0d", i), data, fr(1'b1, 7'(i % 128), 16'(i * 4)));
            idle();
        end
        chk("wrap_drop1", drop1, 0);

        // Drop counter saturates: one frame held, 259 dropped.
        do_reset();
        ready = 1'b0;
        for (int i = 0; i < 260; i++) send_frame(0, 16'h0000);
        chk("sat_drop0", drop0, 8'd255);
        chk("sat_valid", valid, 1);
        chk("sat_drop1", drop1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
